video_in_pack: RTL
==================

Name: video_in_pack

Overview:
Capture stage directly downstream of the video output generator. Samples the 8-bit pixel stream qualified by frame_valid/line_valid and packs 4 consecutive pixels into 32-bit words. Writes the words into the write side of a FIFO for the memory-write path. Checks line length and frame height, and reports frame boundaries and error conditions.

Parameters:
WIDTH, 640, active pixels per line; must be a multiple of 4
HEIGHT, 480, active lines per frame

Ports:
clk  in  1  pixel/system clock; video inputs are synchronous to it
nRST  in  1  asynchronous reset, active low
pixel_in  in  8  pixel data, valid when frame_valid & line_valid
frame_valid  in  1  frame active
line_valid  in  1  line active
clr_err  in  1  clears sticky error flags
fifo_full  in  1  FIFO cannot accept a write this cycle
w_en  out  1  FIFO write strobe, one cycle per word
w_data  out  32  packed word; first pixel of the group in [7:0], fourth in [31:24]
frame_start  out  1  one-cycle pulse on first accepted frame
frame_done  out  1  one-cycle pulse at frame end
line_err  out  1  sticky: bad line length or bad line count
ovf_err  out  1  sticky: word dropped because FIFO full

Behaviour:
- Reset (async on nRST low) clears all counters and the pack register. All outputs are 0. State goes to SYNC.
- Inputs are registered once (fv_q, lv_q, pix_q). Edge detection compares the registered value with the previous registered value.
- State SYNC: wait for fv_q = 0, so capture never starts mid-frame, then go to IDLE.
- State IDLE: on fv_q rising, go to FRAME. Pulse frame_start, clear line_cnt.
- State FRAME: between lines.
  - On lv_q rising, go to LINE. Clear pix_cnt and byte_idx.
  - On fv_q falling, go to IDLE and pulse frame_done.
  - If line_cnt != HEIGHT at that point, set line_err.
- State LINE: each cycle with lv_q = 1:
  - Store pix_q in byte lane byte_idx.
  - Increment byte_idx (2-bit, wraps 3→0).
  - Increment pix_cnt, saturating at 2^clog2(WIDTH+1)-1.
- Word write: when the 4th byte is stored, w_en = 1 on the next cycle and w_data holds the word. Latency is 2 clk from the 4th pixel at the ports to w_en. w_en is never high for two consecutive cycles.
- Overflow: if fifo_full = 1 in the cycle w_en would assert, w_en stays 0, the word is dropped and ovf_err is set.
- Line end: on lv_q falling, go to FRAME and increment line_cnt (saturating).
  - If pix_cnt != WIDTH, set line_err.
  - Partial word (byte_idx != 0) is discarded, never written.
- Simultaneous fv_q and lv_q falling in LINE:
  - Apply the line-end processing first, then the frame end.
  - Go to IDLE and pulse frame_done.
  - The height check includes that final line.
- lv_q = 1 while fv_q = 0 (IDLE/SYNC): ignored, no write, no error.
- line_err and ovf_err hold until clr_err = 1. If a set and a clear happen in the same cycle, set wins.
- Only one frame_start/frame_done per frame. Pulses last exactly 1 cycle.
- Blanking lengths (between lines and frames) are unconstrained. A minimum of 1 cycle low is supported.

Test Plan:
1. WIDTH=8, HEIGHT=2: frame of 2 lines, pixels 0x01..0x10, 4-cycle blanking. Expect exactly 4 writes: 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D. Expect frame_start and frame_done each pulse once, line_err=0, ovf_err=0.
2. Line of 6 pixels with WIDTH=8. Expect 1 write (0x04030201), the partial word discarded, line_err=1. Pulse clr_err and check line_err returns to 0.
3. Frame with 3 lines and HEIGHT=2. Expect line_err=1 at frame_valid fall, frame_done pulsed, 6 words written.
4. Hold fifo_full=1 during the 2nd word of a line. Expect that word absent from the writes, ovf_err=1, and the other words intact.
5. Release nRST while frame_valid=1 mid-frame. Expect no writes until frame_valid goes 0 then 1. The next full frame is then captured correctly with no errors.
6. frame_valid and line_valid fall in the same cycle on the last line. Expect frame_done pulsed once and line_count accepted with line_err=0. Also apply line_valid pulses with frame_valid=0 and expect no writes.

Source files
------------

// File: rtl/video_in_pack.sv
// Capture stage for the video output stream: registers the pixel bus, packs four
// pixels per 32-bit FIFO word, and checks line length and frame height.
module video_in_pack #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [7:0]  pixel_in,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic        clr_err,
  input  logic        fifo_full,
  output logic        w_en,
  output logic [31:0] w_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic        ovf_err
);

  localparam int PC_W = $clog2(WIDTH + 1);
  // One extra count of headroom so a saturated line count never aliases HEIGHT.
  localparam int LC_W = $clog2(HEIGHT + 2);
  localparam logic [PC_W-1:0] PIX_MAX  = {PC_W{1'b1}};
  localparam logic [LC_W-1:0] LINE_MAX = {LC_W{1'b1}};

  typedef enum logic [1:0] {SYNC, IDLE, FRAME, LINE} state_t;

  state_t            state;
  logic              fv_q, lv_q, fv_d, lv_d;
  logic [7:0]        pix_q;
  logic [23:0]       pack;
  logic [1:0]        byte_idx;
  logic [PC_W-1:0]   pix_cnt;
  logic [LC_W-1:0]   line_cnt;
  logic [LC_W-1:0]   line_cnt_inc;
  logic              wr_pend;
  logic              fv_rise, lv_rise;

  assign fv_rise      = fv_q & ~fv_d;
  assign lv_rise      = lv_q & ~lv_d;
  assign line_cnt_inc = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + 1'b1;

  // The write is held off whenever the FIFO reports full in the write cycle.
  assign w_en = wr_pend & ~fifo_full;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= SYNC;
      // Frame-valid history resets high so a frame already in progress at
      // reset release is not mistaken for a rising edge.
      fv_q        <= 1'b1;
      fv_d        <= 1'b1;
      lv_q        <= 1'b0;
      lv_d        <= 1'b0;
      pix_q       <= '0;
      pack        <= '0;
      byte_idx    <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      wr_pend     <= 1'b0;
      w_data      <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      fv_q        <= frame_valid;
      lv_q        <= line_valid;
      pix_q       <= pixel_in;
      fv_d        <= fv_q;
      lv_d        <= lv_q;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      wr_pend     <= 1'b0;
      line_err    <= line_err & ~clr_err;
      ovf_err     <= ovf_err & ~clr_err;
      if (wr_pend && fifo_full) ovf_err <= 1'b1;

      case (state)
        SYNC: begin
          if (!fv_q) state <= IDLE;
        end
        IDLE: begin
          if (fv_rise) begin
            frame_start <= 1'b1;
            line_cnt    <= '0;
            if (lv_rise) begin
              state     <= LINE;
              pack[7:0] <= pix_q;
              byte_idx  <= 2'd1;
              pix_cnt   <= PC_W'(1);
            end else begin
              state <= FRAME;
            end
          end
        end
        FRAME: begin
          if (!fv_q) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            if (line_cnt != LC_W'(HEIGHT)) line_err <= 1'b1;
          end else if (lv_rise) begin
            // The first pixel of the line arrives with the edge itself.
            state     <= LINE;
            pack[7:0] <= pix_q;
            byte_idx  <= 2'd1;
            pix_cnt   <= PC_W'(1);
          end
        end
        LINE: begin
          if (lv_q && fv_q) begin
            byte_idx <= byte_idx + 2'd1;
            if (pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 1'b1;
            case (byte_idx)
              2'd0:    pack[7:0]   <= pix_q;
              2'd1:    pack[15:8]  <= pix_q;
              2'd2:    pack[23:16] <= pix_q;
              default: begin
                w_data  <= {pix_q, pack};
                wr_pend <= 1'b1;
              end
            endcase
          end else begin
            // Line end first; a partial word in pack is simply abandoned.
            line_cnt <= line_cnt_inc;
            if (pix_cnt != PC_W'(WIDTH)) line_err <= 1'b1;
            if (!fv_q) begin
              state      <= IDLE;
              frame_done <= 1'b1;
              if (line_cnt_inc != LC_W'(HEIGHT)) line_err <= 1'b1;
            end else begin
              state <= FRAME;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
